// File: rtl/lbp_pkg.sv
// Shared definitions for the LBP host-side memory responder.
package lbp_pkg;

    localparam int unsigned IMG_W_DEF = 128;
    localparam int unsigned IMG_H_DEF = 128;
    localparam int unsigned AW_DEF    = 14;
    localparam int unsigned PIX_W     = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SERVE,
        ST_DUMP,
        ST_DONE
    } state_e;

endpackage

// File: rtl/lbp_sp_ram.sv
// Simple dual-address RAM: one write port, one registered read port with enable.
module lbp_sp_ram #(
    parameter int unsigned DEPTH = 16384,
    parameter int unsigned AW    = 14,
    parameter int unsigned DW    = 8
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Read data holds whenever no read is issued.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/lbp_host_mem.sv
// Host-side image/result memory for the LBP engine: load, serve reads and
// result writes, then stream the result image out.
module lbp_host_mem
    import lbp_pkg::*;
#(
    parameter int unsigned IMG_W = IMG_W_DEF,
    parameter int unsigned IMG_H = IMG_H_DEF,
    parameter int unsigned AW    = AW_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [PIX_W-1:0] load_data,
    output logic             load_ready,
    output logic             gray_ready,
    input  logic             gray_req,
    input  logic [AW-1:0]    gray_addr,
    output logic [PIX_W-1:0] gray_data,
    input  logic             lbp_valid,
    input  logic [AW-1:0]    lbp_addr,
    input  logic [PIX_W-1:0] lbp_data,
    input  logic             finish,
    output logic             dump_valid,
    output logic [PIX_W-1:0] dump_data,
    input  logic             dump_ready,
    output logic             done,
    output logic             addr_err
);

    localparam int unsigned   N     = IMG_W * IMG_H;
    localparam int unsigned   IW    = $clog2(N);
    localparam logic [AW:0]   N_EXT = (AW+1)'(N);
    localparam logic [AW-1:0] LAST  = AW'(N - 1);

    state_e        state_q, state_d;
    logic [AW-1:0] pix_q, pix_d;
    logic          load_ready_q, load_ready_d;
    logic          gray_ready_q, gray_ready_d;
    logic          dump_valid_q, dump_valid_d;
    logic          done_q, done_d;
    logic          addr_err_q, addr_err_d;

    logic load_xfer, serve, rd_act, wr_act, rd_ok, wr_ok;
    logic img_re, res_we, res_re;
    logic [AW-1:0]    res_waddr, res_raddr;
    logic [PIX_W-1:0] res_wdata;

    assign load_xfer = load_ready_q & load_valid;
    assign serve     = (state_q == ST_SERVE);
    assign rd_act    = serve & gray_req;
    assign wr_act    = serve & lbp_valid;
    assign rd_ok     = {1'b0, gray_addr} < N_EXT;
    assign wr_ok     = {1'b0, lbp_addr} < N_EXT;

    assign img_re    = rd_act & rd_ok;
    assign res_we    = load_xfer | (wr_act & wr_ok);
    assign res_waddr = load_xfer ? pix_q : lbp_addr;
    assign res_wdata = load_xfer ? '0 : lbp_data;

    // Dump prefetches the next pixel on each transfer so one pixel/cycle is sustained.
    assign res_re    = (state_q == ST_DUMP) &
                       (!dump_valid_q | (dump_ready & (pix_q != LAST)));
    assign res_raddr = dump_valid_q ? pix_q + AW'(1) : pix_q;

    always_comb begin
        state_d      = state_q;
        pix_d        = pix_q;
        load_ready_d = load_ready_q;
        gray_ready_d = gray_ready_q;
        dump_valid_d = dump_valid_q;
        done_d       = 1'b0;
        addr_err_d   = addr_err_q | (rd_act & !rd_ok) | (wr_act & !wr_ok);
        case (state_q)
            ST_IDLE: begin
                pix_d        = '0;
                load_ready_d = 1'b1;
                state_d      = ST_LOAD;
            end
            ST_LOAD: begin
                if (load_xfer) begin
                    if (pix_q == LAST) begin
                        pix_d        = '0;
                        load_ready_d = 1'b0;
                        gray_ready_d = 1'b1;
                        state_d      = ST_SERVE;
                    end else begin
                        pix_d = pix_q + AW'(1);
                    end
                end
            end
            ST_SERVE: begin
                if (finish) begin
                    pix_d        = '0;
                    gray_ready_d = 1'b0;
                    state_d      = ST_DUMP;
                end
            end
            ST_DUMP: begin
                if (!dump_valid_q) begin
                    dump_valid_d = 1'b1;
                end else if (dump_ready) begin
                    if (pix_q == LAST) begin
                        dump_valid_d = 1'b0;
                        done_d       = 1'b1;
                        state_d      = ST_DONE;
                    end else begin
                        pix_d = pix_q + AW'(1);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            pix_q        <= '0;
            load_ready_q <= 1'b0;
            gray_ready_q <= 1'b0;
            dump_valid_q <= 1'b0;
            done_q       <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pix_q        <= pix_d;
            load_ready_q <= load_ready_d;
            gray_ready_q <= gray_ready_d;
            dump_valid_q <= dump_valid_d;
            done_q       <= done_d;
            addr_err_q   <= addr_err_d;
        end
    end

    lbp_sp_ram #(.DEPTH(N), .AW(IW), .DW(PIX_W)) u_img (
        .clk_i   (clk),
        .rst_ni  (reset),
        .we_i    (load_xfer),
        .waddr_i (pix_q[IW-1:0]),
        .wdata_i (load_data),
        .re_i    (img_re),
        .raddr_i (gray_addr[IW-1:0]),
        .rdata_o (gray_data)
    );

    lbp_sp_ram #(.DEPTH(N), .AW(IW), .DW(PIX_W)) u_res (
        .clk_i   (clk),
        .rst_ni  (reset),
        .we_i    (res_we),
        .waddr_i (res_waddr[IW-1:0]),
        .wdata_i (res_wdata),
        .re_i    (res_re),
        .raddr_i (res_raddr[IW-1:0]),
        .rdata_o (dump_data)
    );

    assign load_ready = load_ready_q;
    assign gray_ready = gray_ready_q;
    assign dump_valid = dump_valid_q;
    assign done       = done_q;
    assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_lbp_host_mem.sv
// Self-checking bench for lbp_host_mem against an array-based frame model.
module tb_lbp_host_mem;

    localparam int unsigned IMG_W = 128;
    localparam int unsigned IMG_H = 128;
    localparam int unsigned AW    = 15;
    localparam int unsigned N     = IMG_W * IMG_H;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          load_valid = 1'b0;
    logic [7:0]    load_data = '0;
    logic          load_ready;
    logic          gray_ready;
    logic          gray_req = 1'b0;
    logic [AW-1:0] gray_addr = '0;
    logic [7:0]    gray_data;
    logic          lbp_valid = 1'b0;
    logic [AW-1:0] lbp_addr = '0;
    logic [7:0]    lbp_data = '0;
    logic          finish = 1'b0;
    logic          dump_valid;
    logic [7:0]    dump_data;
    logic          dump_ready = 1'b0;
    logic          done;
    logic          addr_err;

    lbp_host_mem #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_data  (load_data),
        .load_ready (load_ready),
        .gray_ready (gray_ready),
        .gray_req   (gray_req),
        .gray_addr  (gray_addr),
        .gray_data  (gray_data),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .lbp_data   (lbp_data),
        .finish     (finish),
        .dump_valid (dump_valid),
        .dump_data  (dump_data),
        .dump_ready (dump_ready),
        .done       (done),
        .addr_err   (addr_err)
    );

    always #5 clk = ~clk;

    int unsigned n_assert = 0;
    int unsigned n_fail   = 0;

    logic [7:0] img_m [N];
    logic [7:0] res_m [N];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_load_ready"}, {31'd0, load_ready}, 0);
        check({tag, "_gray_ready"}, {31'd0, gray_ready}, 0);
        check({tag, "_dump_valid"}, {31'd0, dump_valid}, 0);
        check({tag, "_done"},       {31'd0, done}, 0);
        check({tag, "_addr_err"},   {31'd0, addr_err}, 0);
        check({tag, "_gray_data"},  {24'd0, gray_data}, 0);
        check({tag, "_dump_data"},  {24'd0, dump_data}, 0);
    endtask

    initial begin
        int unsigned cnt;
        int unsigned cyc;
        int unsigned didx;
        logic [7:0]  exp_g;
        logic [7:0]  prev_data;
        logic        prev_stall;

        repeat (3) step();
        check_all_zero("reset");
        reset = 1'b1;

        // Partial frame of junk, aborted by reset at pix 500.
        load_valid = 1'b1;
        for (int c = 0; c < 10 && !load_ready; c++) step();
        check("first_load_ready", {31'd0, load_ready}, 1);
        cnt = 0;
        for (int c = 0; c < 1000 && cnt < 500; c++) begin
            load_data = 8'($urandom);
            if (load_ready) cnt++;
            step();
        end
        check("partial_load_count", cnt, 500);
        reset = 1'b0;
        #1;
        check_all_zero("midload_reset");
        step();
        reset = 1'b1;

        // Ramp load; reads, writes and finish during LOAD must be ignored.
        gray_req  = 1'b1;
        gray_addr = AW'(5);
        lbp_valid = 1'b1;
        lbp_addr  = AW'(3);
        lbp_data  = 8'hFF;
        finish    = 1'b1;
        for (int c = 0; c < 10 && !load_ready; c++) step();
        check("reload_ready", {31'd0, load_ready}, 1);
        cnt = 0;
        cyc = 0;
        for (int c = 0; c < int'(N) + 100 && cnt < N; c++) begin
            load_data = cnt[7:0];
            if (load_ready) begin
                img_m[cnt] = cnt[7:0];
                res_m[cnt] = 8'h00;
                cnt++;
            end
            step();
            cyc++;
        end
        check("load_cycles", cyc, N);
        check("load_ready_fall", {31'd0, load_ready}, 0);
        check("gray_ready_rise", {31'd0, gray_ready}, 1);
        check("gray_data_load_ignored", {24'd0, gray_data}, 0);
        check("addr_err_after_load", {31'd0, addr_err}, 0);
        gray_req  = 1'b0;
        lbp_valid = 1'b0;
        finish    = 1'b0;

        // Back-to-back reads, then a hold cycle.
        gray_req  = 1'b1;
        gray_addr = AW'(129);
        step();
        check("read_129", {24'd0, gray_data}, {24'd0, img_m[129]});
        gray_addr = AW'(130);
        step();
        check("read_130", {24'd0, gray_data}, {24'd0, img_m[130]});
        gray_req  = 1'b0;
        gray_addr = AW'(7);
        step();
        check("read_hold", {24'd0, gray_data}, {24'd0, img_m[130]});
        exp_g = img_m[130];

        // Random mix of reads and result writes.
        for (int c = 0; c < 200; c++) begin
            gray_req  = 1'($urandom_range(1, 0));
            gray_addr = AW'($urandom_range(N - 1, 0));
            lbp_valid = 1'($urandom_range(1, 0));
            lbp_addr  = AW'($urandom_range(N - 1, 1));
            lbp_data  = 8'($urandom);
            step();
            if (gray_req)  exp_g = img_m[gray_addr];
            if (lbp_valid) res_m[lbp_addr] = lbp_data;
            check("serve_gray_data", {24'd0, gray_data}, {24'd0, exp_g});
        end
        gray_req  = 1'b0;
        check("serve_addr_err", {31'd0, addr_err}, 0);

        // Overwrite of the same result address.
        lbp_valid = 1'b1;
        lbp_addr  = AW'(129);
        lbp_data  = 8'hA5;
        step();
        lbp_data  = 8'h3C;
        step();
        res_m[129] = 8'h3C;
        lbp_valid = 1'b0;

        // Out-of-range read and write are dropped and flag addr_err.
        gray_req  = 1'b1;
        gray_addr = AW'(N);
        step();
        gray_req  = 1'b0;
        check("oob_read_data", {24'd0, gray_data}, {24'd0, exp_g});
        check("oob_read_err", {31'd0, addr_err}, 1);
        lbp_valid = 1'b1;
        lbp_addr  = AW'(N + 100);
        lbp_data  = 8'hEE;
        step();
        check("oob_write_err", {31'd0, addr_err}, 1);

        // finish with a coincident in-range write.
        lbp_addr  = AW'(7);
        lbp_data  = 8'h77;
        finish    = 1'b1;
        step();
        res_m[7]  = 8'h77;
        lbp_valid = 1'b0;
        finish    = 1'b0;
        check("gray_ready_fall", {31'd0, gray_ready}, 0);
        check("dump_valid_first_cycle", {31'd0, dump_valid}, 0);

        // Dump with dump_ready alternating 1/0.
        didx = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int c = 0; c < 3 * int'(N) && didx < N; c++) begin
            dump_ready = (c % 2 == 0);
            if (dump_valid) begin
                check("dump_data", {24'd0, dump_data}, {24'd0, res_m[didx]});
                if (prev_stall) check("dump_stall_stable", {24'd0, dump_data}, {24'd0, prev_data});
                prev_stall = !dump_ready;
                prev_data  = dump_data;
                if (dump_ready) didx++;
            end
            step();
        end
        check("dump_count", didx, N);
        dump_ready = 1'b1;
        check("done_pulse", {31'd0, done}, 1);
        check("dump_valid_after_last", {31'd0, dump_valid}, 0);
        step();
        check("done_one_cycle", {31'd0, done}, 0);
        step();
        check("new_frame_load_ready", {31'd0, load_ready}, 1);
        check("addr_err_sticky", {31'd0, addr_err}, 1);

        reset = 1'b0;
        #1;
        check("addr_err_cleared", {31'd0, addr_err}, 0);
        check("load_ready_reset", {31'd0, load_ready}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
